stream_demux8: RTL and testbench
================================

// Module: stream_demux8
// PURPOSE
//  1-to-8 packet stream router: one N-bit valid/ready input stream is steered to
//  one of eight valid/ready output channels. It is the inverse of the 8:1 selector.
//  The channel is sampled on the first beat of a packet and held until the last beat.
//  A single registered output stage decouples timing. It sits between a shared
//  producer (e.g. a bus master) and eight per-unit consumers.
// PARAMETERS
//  N  32  data width of every beat
// PORTS
//  clk        in   1    system clock; all state updates on posedge
//  rst        in   1    synchronous, active-high reset
//  in_data    in   N    input beat payload
//  in_sel     in   3    destination channel; sampled only on first beat of a packet
//  in_last    in   1    marks final beat of packet (single-beat packet: last=1)
//  in_valid   in   1    input beat valid
//  in_ready   out  1    router can accept a beat this cycle
//  out_data   out  N    registered payload, broadcast to all channels
//  out_last   out  1    registered last flag, broadcast
//  out_valid  out  8    one-hot valid; bit i = beat presented to channel i
//  out_ready  in   8    per-channel ready from consumers
//  busy       out  1    1 while a multi-beat packet is open (FSM in ROUTE)
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - FSM=IDLE, lock_sel=0, stage empty.
//    - out_valid=0, out_data=0, out_last=0, busy=0.
//    - Reset mid-packet discards the open packet and any staged beat; nothing is emitted.
//  - Output stage: one entry {data,last,sel,full}.
//    - out_valid[i] = full && (sel==i).
//    - out_valid is never multi-hot.
//    - Drain when full && out_ready[sel]. Ready on other channels is ignored.
//  - in_ready = !full || out_ready[sel]. Combinational; independent of in_valid.
//  - Accept = in_valid && in_ready. On accept the stage loads the beat at the next edge.
//    - Latency: 1 cycle from accept to out_valid.
//    - Throughput: 1 beat/cycle under continuous ready.
//  - Channel used: ch = (FSM==IDLE) ? in_sel : lock_sel.
//  - FSM:
//    - IDLE --accept & !in_last--> ROUTE, lock_sel<=in_sel.
//    - IDLE --accept & in_last--> IDLE (single-beat packet).
//    - ROUTE --accept & in_last--> IDLE.
//    - ROUTE --accept & !in_last--> ROUTE.
//    - No accept: state and lock_sel hold.
//  - In ROUTE, in_sel is ignored; a changing in_sel never splits a packet.
//  - busy = (FSM==ROUTE).
//  - Simultaneous drain and accept in the same cycle: the stage reloads and stays full, with no bubble.
//    - This holds even when the new beat targets a different channel.
//  - Stall: full && !out_ready[sel] -> in_ready=0. out_data, out_last and out_valid hold stable until drained.
//  - Data is passed unmodified; no width conversion and no reordering.
//    Beats leave in exactly the order they were accepted.
//  - in_valid=1 with X/any in_sel in ROUTE must not affect routing.
// TESTING
//  1 Single beat: in_sel=5, last=1, data=0xDEADBEEF, out_ready=8'hFF
//    -> next cycle out_valid=8'h20, out_data=0xDEADBEEF, out_last=1; busy stays 0.
//  2 3-beat packet, in_sel=2 then 6 then 7 on beats 1-3
//    -> all three beats on out_valid=8'h04; busy=1 after beat 1, busy=0 after beat 3.
//  3 Backpressure: out_ready[3]=0 with beat staged for ch3
//    -> in_ready=0, out_* hold 4 cycles; raise out_ready[3] -> next beat accepted same cycle, no bubble.
//  4 Back-to-back single beats to ch0,1,...,7, all ready
//    -> 8 beats emitted on consecutive cycles, out_valid walks 01,02,...,80.
//  5 Wrong-channel ready: stage full for ch4, out_ready=8'hEF
//    -> no drain, in_ready=0.
//  6 rst asserted on beat 2 of a 4-beat packet to ch1
//    -> next cycle out_valid=0, busy=0; next packet with in_sel=3 routes to ch3.

Source files
------------

// File: rtl/stream_demux8.sv
// 1-to-8 packet router: one valid/ready input steered to one of eight one-hot valid outputs, channel locked per packet.
// Latency: 1 cycle from accept to out_valid through a single registered output stage.
// Backpressure: in_ready = stage empty or staged channel ready; ready on other channels is ignored.
module stream_demux8 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic [2:0]   in_sel,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic         busy
);

  typedef enum logic {IDLE = 1'b0, ROUTE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] lock_sel_q, lock_sel_d;

  logic       stg_full;
  logic [2:0] stg_sel;
  logic       accept;
  logic [2:0] ch;

  // Accept and channel selection; a packet's channel comes from its first beat only
  always_comb begin
    accept = in_valid && in_ready;
    ch     = (state_q == IDLE) ? in_sel : lock_sel_q;
  end

  // Packet FSM state and locked channel
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // Next state: open a packet on a non-last first beat, close it on the last beat
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d    = ROUTE;
            lock_sel_d = in_sel;
          end
        end
        ROUTE: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM-derived and stage-derived outputs
  always_comb begin
    busy      = (state_q == ROUTE);
    in_ready  = !stg_full || out_ready[stg_sel];
    out_valid = 8'h00;
    if (stg_full) out_valid[stg_sel] = 1'b1;
  end

  // Output stage: load on accept (even while draining, so no bubble), empty on drain alone
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_full <= 1'b0;
      stg_sel  <= 3'd0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      stg_full <= 1'b1;
      stg_sel  <= ch;
      out_data <= in_data;
      out_last <= in_last;
    end else if (stg_full && out_ready[stg_sel]) begin
      stg_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_demux8.sv
module tb_stream_demux8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic        busy;

  stream_demux8 #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [2:0] cur_ch;
  logic       exp_busy   = 1'b0;
  logic       prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [7:0]  prev_valid;
  logic        rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: pops on every drain, pushes on every accept
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_busy   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        beat_t e;
        chk("busy", {63'd0, busy}, {63'd0, exp_busy});
        chk("onehot", {63'd0, ($countones(out_valid) <= 1)}, 64'd1);
        if (prev_stall) begin
          chk("stall_data", {32'd0, out_data}, {32'd0, prev_data});
          chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
          chk("stall_valid", {56'd0, out_valid}, {56'd0, prev_valid});
        end
        if (|(out_valid & out_ready)) begin
          if (sb.size() == 0) begin
            chk("spurious_beat", {56'd0, out_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_valid", {56'd0, out_valid}, {56'd0, (8'h01 << e.ch)});
            chk("sb_data", {32'd0, out_data}, {32'd0, e.data});
            chk("sb_last", {63'd0, out_last}, {63'd0, e.last});
          end
        end
        prev_stall = (out_valid != 8'h00) && !(|(out_valid & out_ready));
        prev_data  = out_data;
        prev_last  = out_last;
        prev_valid = out_valid;
        if (in_valid && in_ready) begin
          e.ch   = cur_ch;
          e.data = in_data;
          e.last = in_last;
          sb.push_back(e);
          exp_busy = !in_last;
        end
      end
    end
  end

  // Random consumer readiness, biased toward ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 8'($urandom | $urandom);
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present a beat; ch is the packet's true destination, sel is what is driven on in_sel
  task automatic offer(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] d, input logic l);
    cur_ch   = ch;
    in_sel   = sel;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
  endtask

  task automatic send_beat(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] d, input logic l);
    bit done = 1'b0;
    offer(ch, sel, d, l);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        align();
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept_within_200");
      align();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int t0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
    out_ready = 8'h00; cur_ch = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {56'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    align();
    rst = 1'b0;

    // 1: single beat to ch5
    out_ready = 8'hFF;
    send_beat(3'd5, 3'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("t1_valid", {56'd0, out_valid}, 64'h20);
    chk("t1_data", {32'd0, out_data}, 64'hDEADBEEF);
    chk("t1_last", {63'd0, out_last}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    align();

    // 2: 3-beat packet to ch2 while in_sel wanders
    send_beat(3'd2, 3'd2, 32'h0000_2001, 1'b0);
    @(negedge clk);
    chk("t2_busy1", {63'd0, busy}, 64'd1);
    chk("t2_valid1", {56'd0, out_valid}, 64'h04);
    align();
    send_beat(3'd2, 3'd6, 32'h0000_2002, 1'b0);
    send_beat(3'd2, 3'd7, 32'h0000_2003, 1'b1);
    @(negedge clk);
    chk("t2_valid3", {56'd0, out_valid}, 64'h04);
    chk("t2_busy3", {63'd0, busy}, 64'd0);
    align();

    // 3: backpressure on ch3, then release with no bubble
    out_ready = 8'hF7;
    send_beat(3'd3, 3'd3, 32'hAAAA_0003, 1'b1);
    offer(3'd3, 3'd3, 32'hBBBB_0003, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("t3_hold_valid", {56'd0, out_valid}, 64'h08);
      chk("t3_hold_data", {32'd0, out_data}, 64'hAAAA_0003);
      align();
    end
    out_ready = 8'hFF;
    @(negedge clk);
    chk("t3_in_ready_rise", {63'd0, in_ready}, 64'd1);
    align();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_next_valid", {56'd0, out_valid}, 64'h08);
    chk("t3_next_data", {32'd0, out_data}, 64'hBBBB_0003);
    align();

    // 4: back-to-back single beats walking ch0..ch7
    t0 = cyc;
    for (int c = 0; c < 8; c++) send_beat(3'(c), 3'(c), 32'h4000_0000 + c, 1'b1);
    chk("t4_cycles", 64'(cyc - t0), 64'd8);

    // 5: staged for ch4, every other channel ready
    align();
    out_ready = 8'hEF;
    send_beat(3'd4, 3'd4, 32'h5555_0004, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_valid", {56'd0, out_valid}, 64'h10);
      chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
      align();
    end
    out_ready = 8'hFF;
    align();

    // 6: reset on beat 2 of a 4-beat packet to ch1
    send_beat(3'd1, 3'd1, 32'h6000_0001, 1'b0);
    offer(3'd1, 3'd1, 32'h6000_0002, 1'b0);
    rst = 1'b1;
    align();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", {56'd0, out_valid}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    align();
    send_beat(3'd3, 3'd3, 32'h6000_0003, 1'b1);
    @(negedge clk);
    chk("t6_new_valid", {56'd0, out_valid}, 64'h08);
    align();

    // Random packets under random consumer readiness
    rnd_ready = 1'b1;
    for (int p = 0; p < 300; p++) begin
      int len;
      logic [2:0] pch;
      len = $urandom_range(1, 4);
      pch = 3'($urandom_range(0, 7));
      for (int b = 0; b < len; b++) begin
        send_beat(pch, (b == 0) ? pch : 3'($urandom_range(0, 7)), $urandom, (b == len - 1));
        if ($urandom_range(0, 3) == 0) align();
      end
    end
    rnd_ready = 1'b0;
    align();
    out_ready = 8'hFF;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
